// File: rtl/cdc_handshake_tx_if.sv
// Handshake bundle for cdc_handshake_tx: the local send port, the
// req/ack/data lines to the receiver, and the completion pulses.
// master = the transmitter block itself; slave = its environment.
interface cdc_handshake_tx_if #(
  parameter int DATA_W = 8
);
  logic              send_valid;
  logic [DATA_W-1:0] send_data;
  logic              send_ready;
  logic              req_out;
  logic [DATA_W-1:0] data_out;
  logic              ack_in;
  logic              done;
  logic              timeout;

  modport master (
    input  send_valid, send_data, ack_in,
    output send_ready, req_out, data_out, done, timeout
  );

  modport slave (
    output send_valid, send_data, ack_in,
    input  send_ready, req_out, data_out, done, timeout
  );
endinterface

// File: rtl/cdc_handshake_tx.sv
// Source side of a 4-phase req/ack handshake. A word accepted from local
// logic is held on registered data_out while registered req_out is high.
// The asynchronous ack_in passes through a SYNC_STAGES flop chain and only
// its last stage (ack_s) steers the FSM. An optional cycle limit in REQ
// aborts a transfer whose receiver never answers.
module cdc_handshake_tx #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,    // legal range 2..4
  parameter int TIMEOUT     = 255   // 0 disables the abort
) (
  input  logic               clk,
  input  logic               nrst,
  cdc_handshake_tx_if.master bus
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RELEASE
  } state_t;

  state_t                 state, state_next;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_s;
  logic                   req_q, req_next;
  logic [DATA_W-1:0]      data_q, data_next;
  logic [CNT_W-1:0]       cnt_q, cnt_next;
  logic                   via_ack_q, via_ack_next;  // RELEASE was entered by ack, not abort
  logic                   done_q, done_next;
  logic                   timeout_q, timeout_next;

  assign ack_s = ack_sync[SYNC_STAGES-1];

  // Synchronizer chain bringing the receiver's ack into this clock domain.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ack_sync <= '0;
    end else begin
      // NOTE: non-blocking so every stage samples the previous stage's old
      // value; blocking here would collapse the chain into a single flop.
      ack_sync <= {ack_sync[SYNC_STAGES-2:0], bus.ack_in};
    end
  end

  // State and all registered outputs; reset drops req_out immediately.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= IDLE;
      req_q     <= 1'b0;
      data_q    <= '0;
      cnt_q     <= '0;
      via_ack_q <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_next;
      req_q     <= req_next;
      data_q    <= data_next;
      cnt_q     <= cnt_next;
      via_ack_q <= via_ack_next;
      done_q    <= done_next;
      timeout_q <= timeout_next;
    end
  end

  // Next-state and next-output logic for the IDLE -> REQ -> RELEASE cycle.
  always_comb begin
    // NOTE: every output gets a hold/idle default first, so no path through
    // the case can leave one unassigned and infer a latch.
    state_next   = state;
    req_next     = req_q;
    data_next    = data_q;
    cnt_next     = cnt_q;
    via_ack_next = via_ack_q;
    done_next    = 1'b0;
    timeout_next = 1'b0;
    unique case (state)
      IDLE: begin
        // A stale ack still high from the previous transfer blocks acceptance.
        if (bus.send_valid && !ack_s) begin
          data_next  = bus.send_data;
          req_next   = 1'b1;
          cnt_next   = '0;
          state_next = REQ;
        end
      end
      REQ: begin
        if (ack_s) begin
          req_next     = 1'b0;
          via_ack_next = 1'b1;
          state_next   = RELEASE;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          req_next     = 1'b0;
          via_ack_next = 1'b0;
          timeout_next = 1'b1;
          state_next   = RELEASE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_next = cnt_q + 1'b1;
        end
      end
      RELEASE: begin
        // Wait as long as it takes for the receiver to drop ack.
        if (!ack_s) begin
          done_next  = via_ack_q;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.send_ready = (state == IDLE) && !ack_s;
  assign bus.req_out    = req_q;
  assign bus.data_out   = data_q;
  assign bus.done       = done_q;
  assign bus.timeout    = timeout_q;

endmodule
